pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 73 +++++++
 tb/tb_pc_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC and return-address registers with a ripple-carry
// PC+1 incrementer and next-PC / RA-source selection for jump, branch, call and return.
module pc_sequencer #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restore,
    input  logic             writePC,
    input  logic             writeRA,
    input  logic             PCsrc,
    input  logic             ImRPC,
    input  logic             conditionalBop,
    input  logic [WIDTH-1:0] RArestore,
    input  logic [WIDTH-1:0] ImR,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_1,
    output logic [WIDTH-1:0] RA
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_pc_1;
    logic [WIDTH-1:0] w_imm_mux;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_ra_src;
    logic             w_imm_sel;
    logic             w_pc_we;

    assign w_addend   = WIDTH'(1);
    assign w_carry[0] = 1'b0;

    // Per-bit full adders; the carry out of the top bit is never formed, so PC_1 wraps.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
        assign w_pc_1[i] = r_pc[i] ^ w_addend[i] ^ w_carry[i];
        if (i + 1 < int'(WIDTH)) begin : g_cout
            assign w_carry[i+1] = (r_pc[i] & w_addend[i])
                                | (w_carry[i] & (r_pc[i] ^ w_addend[i]));
        end
    end

    // A taken branch both forces the PC write and steers the immediate target in.
    assign w_imm_sel = ImRPC | conditionalBop;
    assign w_pc_we   = writePC | conditionalBop;

    assign w_imm_mux = w_imm_sel ? ImR  : w_pc_1;
    assign w_next_pc = PCsrc     ? r_ra : w_imm_mux;
    assign w_ra_src  = restore   ? RArestore : w_pc_1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_pc_we) begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra <= RESET_PC;
        end else if (writeRA) begin
            r_ra <= w_ra_src;
        end
    end

    assign PC   = r_pc;
    assign RA   = r_ra;
    assign PC_1 = w_pc_1;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset sequences,
// and randomized stimulus against a behavioural model of the PC/RA rules.
module tb_pc_sequencer;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         restore;
    logic         writePC;
    logic         writeRA;
    logic         PCsrc;
    logic         ImRPC;
    logic         conditionalBop;
    logic [W-1:0] RArestore;
    logic [W-1:0] ImR;
    logic [W-1:0] PC;
    logic [W-1:0] PC_1;
    logic [W-1:0] RA;

    int n_tests;
    int n_fail;

    pc_sequencer #(.WIDTH(W), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .restore        (restore),
        .writePC        (writePC),
        .writeRA        (writeRA),
        .PCsrc          (PCsrc),
        .ImRPC          (ImRPC),
        .conditionalBop (conditionalBop),
        .RArestore      (RArestore),
        .ImR            (ImR),
        .PC             (PC),
        .PC_1           (PC_1),
        .RA             (RA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         restore;
        logic         wpc;
        logic         wra;
        logic         pcsrc;
        logic         imrpc;
        logic         cbop;
        logic [W-1:0] rar;
        logic [W-1:0] imr;
        logic [W-1:0] exp_pc;
        logic [W-1:0] exp_ra;
        logic [W-1:0] exp_pc1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] e_pc,
                             input logic [W-1:0] e_ra, input logic [W-1:0] e_pc1);
        check({tag, " PC"},   PC,   e_pc);
        check({tag, " RA"},   RA,   e_ra);
        check({tag, " PC_1"}, PC_1, e_pc1);
    endtask

    task automatic drive(input logic rs, input logic wpc, input logic wra, input logic pcs,
                         input logic imr_pc, input logic cb, input logic [W-1:0] rar,
                         input logic [W-1:0] imr);
        restore        = rs;
        writePC        = wpc;
        writeRA        = wra;
        PCsrc          = pcs;
        ImRPC          = imr_pc;
        conditionalBop = cb;
        RArestore      = rar;
        ImR            = imr;
    endtask

    // Reference model state: values the registers should hold after each edge.
    logic [W-1:0] m_pc;
    logic [W-1:0] m_ra;

    function automatic logic [W-1:0] inc(input logic [W-1:0] v);
        int unsigned s;
        s = (int'(v) + 1) % (1 << W);
        return W'(s);
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, '0, '0);

        // restore wpc wra pcsrc imrpc cbop  RArestore ImR   -> PC RA PC_1
        vecs.push_back('{0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0002});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0003});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0004});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 16'h0000, 16'h0010, 16'h0010, 16'h0000, 16'h0011});
        vecs.push_back('{0, 1, 1, 0, 1, 0, 16'h0000, 16'h0200, 16'h0200, 16'h0011, 16'h0201});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0011, 16'h0011, 16'h0012});
        vecs.push_back('{0, 0, 0, 0, 0, 1, 16'h0000, 16'h1234, 16'h1234, 16'h0011, 16'h1235});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 16'h0000, 16'h5555, 16'h1234, 16'h0011, 16'h1235});
        vecs.push_back('{1, 0, 1, 0, 0, 0, 16'hBEEF, 16'h0000, 16'h1234, 16'hBEEF, 16'h1235});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hBEEF, 16'h0000});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0001});
        vecs.push_back('{0, 0, 0, 1, 1, 1, 16'h0000, 16'h7777, 16'hBEEF, 16'hBEEF, 16'hBEF0});
        vecs.push_back('{1, 0, 1, 0, 0, 0, 16'h4000, 16'h0000, 16'hBEEF, 16'h4000, 16'hBEF0});
        vecs.push_back('{0, 1, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h4000, 16'hBEF0, 16'h4001});
        vecs.push_back('{1, 1, 1, 1, 0, 0, 16'h0ABC, 16'h0000, 16'hBEF0, 16'h0ABC, 16'hBEF1});
        vecs.push_back('{0, 0, 0, 0, 1, 0, 16'h0000, 16'h1111, 16'hBEF0, 16'h0ABC, 16'hBEF1});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEF0, 16'hBEF1, 16'hBEF1});

        // Reset held: values valid before any clock edge and across edges.
        #1;
        check_all("reset_async", 16'h0000, 16'h0000, 16'h0001);
        drive(0, 1, 1, 0, 1, 1, 16'hAAAA, 16'h5555);
        @(posedge clk); #1;
        check_all("reset_held_edge", 16'h0000, 16'h0000, 16'h0001);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, '0, '0);
        rst_n = 1'b1;
        #1;
        check_all("reset_release", 16'h0000, 16'h0000, 16'h0001);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].restore, vecs[k].wpc, vecs[k].wra, vecs[k].pcsrc,
                  vecs[k].imrpc, vecs[k].cbop, vecs[k].rar, vecs[k].imr);
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", k), vecs[k].exp_pc, vecs[k].exp_ra, vecs[k].exp_pc1);
        end

        // Reset asserted between edges with writes pending: discarded, clears at once.
        @(negedge clk);
        drive(0, 1, 1, 0, 0, 0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midseq_reset", 16'h0000, 16'h0000, 16'h0001);
        @(posedge clk); #1;
        check_all("midseq_reset_edge", 16'h0000, 16'h0000, 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("first_after_release_pre", 16'h0000, 16'h0000, 16'h0001);
        @(posedge clk); #1;
        check_all("first_after_release", 16'h0001, 16'h0001, 16'h0002);

        // Randomized run against the rule-level model.
        m_pc = 16'h0001;
        m_ra = 16'h0001;
        for (int it = 0; it < 400; it++) begin
            logic [W-1:0] old_pc;
            logic [W-1:0] old_ra;
            @(negedge clk);
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0),
                  W'($urandom), W'($urandom));
            rst_n = ($urandom_range(0, 39) != 0);
            old_pc = m_pc;
            old_ra = m_ra;
            if (!rst_n) begin
                m_pc = '0;
                m_ra = '0;
            end else begin
                if (writePC || conditionalBop) begin
                    if (PCsrc)                       m_pc = old_ra;
                    else if (ImRPC || conditionalBop) m_pc = ImR;
                    else                              m_pc = inc(old_pc);
                end
                if (writeRA) m_ra = restore ? RArestore : inc(old_pc);
            end
            @(posedge clk); #1;
            check_all($sformatf("rand%0d", it), m_pc, m_ra, inc(m_pc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
